// File: rtl/msg_pkg.sv
`timescale 1ns/1ps
// Shared widths, default message contents and debouncer state encoding for message_scroller.
package msg_pkg;
  localparam int CHAR_W  = 4;
  localparam int MSG_LEN = 16;
  localparam int ADDR_W  = 4;

  typedef logic [CHAR_W-1:0] char_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Character i sits in nibble i, so the power-up message reads 0..F.
  localparam logic [MSG_LEN*CHAR_W-1:0] DEFAULT_MSG = 64'hFEDC_BA98_7654_3210;

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, HELD, WAIT_RELEASE} dbnc_state_t;

  function automatic char_t default_char(input int idx);
    return DEFAULT_MSG[idx*CHAR_W +: CHAR_W];
  endfunction
endpackage

// File: rtl/message_scroller_debouncer.sv
`timescale 1ns/1ps
// Two-flop synchronizer plus press/release debouncer; btn_pulse is a registered
// one-cycle strobe once a press has been stable for DEBOUNCE_CYCLES cycles.
module button_debouncer
  import msg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65_536
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_step,
  output logic btn_pulse
);
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             w_btn_sync;
  dbnc_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;

  assign w_btn_sync = r_sync[1];
  assign btn_pulse  = r_pulse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= 2'b00;
    else       r_sync <= {r_sync[0], btn_step};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        IDLE: if (w_btn_sync) begin
          r_cnt   <= '0;
          r_state <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (!w_btn_sync) r_state <= IDLE;
          else if (r_cnt == CNT_LAST) begin
            r_state <= HELD;
            r_pulse <= 1'b1;
          end else r_cnt <= r_cnt + 1'b1;
        end
        // A held button waits here indefinitely and never re-triggers.
        HELD: if (!w_btn_sync) begin
          r_cnt   <= '0;
          r_state <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (w_btn_sync) r_state <= HELD;
          else if (r_cnt == CNT_LAST) r_state <= IDLE;
          else r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/message_scroller.sv
`timescale 1ns/1ps
// 16-character hex message with a 4-character scrolling window for the LED driver.
// Window start advances on auto tick or debounced button; char outputs lag by one cycle.
module message_scroller
  import msg_pkg::*;
#(
  parameter int SCROLL_DIV      = 1_000_000,
  parameter int DEBOUNCE_CYCLES = 65_536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_step,
  input  logic              auto_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CHAR_W-1:0] wr_data,
  output logic [CHAR_W-1:0] char3,
  output logic [CHAR_W-1:0] char2,
  output logic [CHAR_W-1:0] char1,
  output logic [CHAR_W-1:0] char0,
  output logic [ADDR_W-1:0] ptr,
  output logic              step_pulse
);
  localparam int              DIV_W    = $clog2(SCROLL_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             w_btn_pulse;
  logic             w_auto_tick;
  logic             w_adv;
  addr_t            r_ptr;
  logic             r_step;
  char_t            r_mem  [MSG_LEN];
  char_t            r_char [4];

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .reset    (reset),
    .btn_step (btn_step),
    .btn_pulse(w_btn_pulse)
  );

  assign w_auto_tick = auto_en && (r_div == DIV_LAST);
  assign w_adv       = w_auto_tick | w_btn_pulse;

  // Held at zero while disabled so re-enabling always yields a full period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_div <= '0;
    else if (!auto_en || w_auto_tick) r_div <= '0;
    else                             r_div <= r_div + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr  <= '0;
      r_step <= 1'b0;
    end else begin
      r_step <= w_adv;
      if (w_adv) r_ptr <= r_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) r_mem[i] <= default_char(i);
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Window index sums wrap naturally in ADDR_W bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) r_char[k] <= default_char(k);
    end else begin
      for (int k = 0; k < 4; k++) r_char[k] <= r_mem[r_ptr + addr_t'(k)];
    end
  end

  assign char3      = r_char[0];
  assign char2      = r_char[1];
  assign char1      = r_char[2];
  assign char0      = r_char[3];
  assign ptr        = r_ptr;
  assign step_pulse = r_step;
endmodule
